adc_serial_rx: RTL and testbench
================================

# adc_serial_rx

Receive-side deserializer for the ADC controller's serial output stream. Samples `SerialOutput` while `DataMark` is high, rebuilds each WIDTH-bit conversion result MSB-first, and checks frame length. Checks each word against the parallel `B` result latched on `LoadReg`. Queues words in a small FIFO with a valid/ready output for downstream logic on the same die.

## Interface
- `WIDTH`, 8, conversion word width in bits (≥2).
- `FIFO_DEPTH`, 4, receive queue depth (power of two, ≥2).

- `clk` in 1: single clock; all inputs are sampled and all outputs driven on its rising edge.
- `clr` in 1: reset; synchronous, active-high.
- `DataMark` in 1: frame enable from the ADC controller; high for exactly WIDTH consecutive cycles per frame.
- `SerialOutput` in 1: serial data bit, valid in every cycle `DataMark`=1; MSB first.
- `LoadReg` in 1: one-cycle pulse, parallel result on `B` valid.
- `B` in WIDTH: parallel conversion result, sampled only when `LoadReg`=1.
- `rx_data` out WIDTH: head-of-FIFO word; first-word fall-through.
- `rx_mismatch` out 1: head word differed from its latched `B` reference.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer accepts head when `rx_valid`&`rx_ready`.
- `frame_err` out 1: one-cycle pulse on a short or long frame.
- `overflow` out 1: one-cycle pulse when a good word is dropped because the FIFO is full.
- `count` out clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Reset (`clr`=1 at an edge):
  - state goes to IDLE; bit counter and shift register clear; `ref_valid` clears; FIFO empties.
  - All outputs go to 0.
  - A partial frame in progress is discarded silently, with no `frame_err`.
- Deserializer FSM:
  - IDLE: when `DataMark`=1, shift in `SerialOutput`, set bitcnt=1, go to SHIFT.
  - SHIFT, `DataMark`=1 and bitcnt<WIDTH: shift left, inserting the bit at the LSB; increment bitcnt.
  - SHIFT, `DataMark`=1 and bitcnt==WIDTH: go to OVERRUN; the word is discarded.
  - SHIFT, `DataMark`=0: if bitcnt==WIDTH, push the word; otherwise pulse `frame_err`. Go to IDLE in both cases.
  - OVERRUN: stay while `DataMark`=1. On `DataMark`=0, pulse `frame_err` and go to IDLE.
- Frame end is detected only by `DataMark` falling, so at least one low cycle between frames is mandatory. A frame cannot restart in the cycle its end is detected.
- Reference check:
  - `LoadReg`=1: ref←`B`, `ref_valid`←1.
  - At push: stored mismatch bit = `ref_valid` & (word≠ref). `ref_valid` then clears.
  - `LoadReg` in the same cycle as a push: the comparison uses the old ref; the new `B` is captured and `ref_valid`=1 afterwards.
- FIFO:
  - Each entry holds {mismatch, word}.
  - Pop occurs when `rx_valid`&`rx_ready`.
  - Push when not full: accepted.
  - Push when full without a pop: word dropped, `overflow` pulses, contents unchanged.
  - Push and pop together when full: both happen; `count` unchanged; no overflow.
  - Push when empty: `rx_ready` has no effect in that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- `frame_err` and `overflow` never assert in the same cycle, because only valid frames push.

## Timing
- Bit k of a frame (k=0 is the MSB) is sampled at the k-th edge with `DataMark`=1.
- Let edge E be the first edge with `DataMark`=0 after a valid frame. The push occurs at E.
- When the FIFO was empty, `rx_valid`=1 and `rx_data`/`rx_mismatch` are valid in the cycle after E. Total latency is 1 cycle from `DataMark` falling.
- `frame_err` is high for exactly the cycle after E.
- `overflow` is high for exactly the cycle after the rejected push.
- `count` updates at the same edge as the push/pop.
- Throughput: one WIDTH-bit word per WIDTH+1 cycles maximum.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Valid frame with matching reference:
  - Stimulus: `LoadReg` pulse with `B`=0xA5, then `DataMark` high 8 cycles with serial 1,0,1,0,0,1,0,1, `rx_ready`=1.
  - Required: one cycle after `DataMark` falls, `rx_valid`=1, `rx_data`=0xA5, `rx_mismatch`=0. `count` returns to 0 after the pop.
- Mismatch:
  - Stimulus: `B`=0x3C latched, then serial frame 0x3D.
  - Required: `rx_data`=0x3D, `rx_mismatch`=1.
  - Stimulus: a following frame 0x3D with no new `LoadReg`.
  - Required: `rx_mismatch`=0.
- Framing errors:
  - Stimulus: a 7-cycle `DataMark` frame, then a 9-cycle frame.
  - Required: `frame_err` pulses exactly once per frame, one cycle after each fall. `count` stays 0 and `rx_valid` stays 0.
- Full FIFO and overflow:
  - Stimulus: `rx_ready`=0; frames 0x01, 0x02, 0x03, 0x04, 0x05.
  - Required: `count`=4; `overflow` pulses once after 0x05. Then with `rx_ready`=1, data pops in the order 0x01–0x04.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full (0x11–0x14), `rx_ready`=1 through the end of frame 0x15.
  - Required: no overflow; `count` stays 4 at the push edge; the pop order ends with 0x15.
- Reset mid-frame:
  - Stimulus: assert `clr` after 4 bits of a frame, then send a full frame 0x81.
  - Required: only 0x81 is received; no `frame_err`; all outputs are 0 the cycle after `clr`.

Source files
------------

// File: rtl/adc_serial_rx.sv
// ---------------------------------------------------------------------------
// adc_serial_rx
//
// Receive-side deserializer for the ADC controller's serial output stream.
// Rebuilds each WIDTH-bit conversion word MSB-first while DataMark is high,
// rejects frames of the wrong length, compares each good word against the
// parallel result B latched on LoadReg, and queues {mismatch, word} in a
// small first-word-fall-through FIFO with a valid/ready consumer interface.
//
// Ports:
//   clk          : single clock, everything on the rising edge
//   clr          : synchronous active-high reset
//   DataMark     : frame enable, high for WIDTH cycles per frame
//   SerialOutput : serial data bit, MSB first, valid while DataMark=1
//   LoadReg      : one-cycle pulse, B holds the parallel reference result
//   B            : parallel conversion result
//   rx_data      : head-of-FIFO word (0 when the FIFO is empty)
//   rx_mismatch  : head word differed from its latched reference
//   rx_valid     : FIFO non-empty
//   rx_ready     : consumer accepts the head word when rx_valid is also high
//   frame_err    : one-cycle pulse after a short or long frame
//   overflow     : one-cycle pulse after a good word is dropped (FIFO full)
//   count        : current FIFO occupancy
// ---------------------------------------------------------------------------
module adc_serial_rx #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        DataMark,
    input  logic                        SerialOutput,
    input  logic                        LoadReg,
    input  logic [WIDTH-1:0]            B,
    output logic [WIDTH-1:0]            rx_data,
    output logic                        rx_mismatch,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] FULL_BITS = CNT_W'(WIDTH);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OVERRUN
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   bitcnt_q;
    logic               frame_err_q;

    logic [WIDTH-1:0]   ref_q;
    logic               ref_valid_q;

    logic [WIDTH:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [OCC_W-1:0]   count_q;
    logic               overflow_q;

    logic               push;
    logic               pop;
    logic               full;
    logic               accept;
    logic               drop;
    logic [WIDTH:0]     entry;
    logic [WIDTH:0]     head;

    // A good frame ends when DataMark falls with exactly WIDTH bits collected.
    // The mismatch flag is formed from the reference held before this edge,
    // so a LoadReg arriving in the same cycle only affects the next word.
    // A full FIFO still accepts a push when the head is popped in that cycle.
    always_comb begin
        push   = (state_q == SHIFT) && !DataMark && (bitcnt_q == FULL_BITS);
        entry  = {ref_valid_q && (shift_q != ref_q), shift_q};
        full   = (count_q == DEPTH_OCC);
        pop    = (count_q != '0) && rx_ready;
        accept = push && (!full || pop);
        drop   = push && full && !pop;
    end

    // Deserializer FSM: collects bits while DataMark is high, parks in
    // OVERRUN once a frame runs past WIDTH bits, and flags any frame whose
    // length is wrong when DataMark finally drops. Reset simply abandons a
    // partial frame without raising frame_err.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (DataMark) begin
                        shift_q  <= {{(WIDTH-1){1'b0}}, SerialOutput};
                        bitcnt_q <= CNT_W'(1);
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (DataMark) begin
                        if (bitcnt_q == FULL_BITS) begin
                            state_q <= OVERRUN;
                        end else begin
                            shift_q  <= {shift_q[WIDTH-2:0], SerialOutput};
                            bitcnt_q <= bitcnt_q + CNT_W'(1);
                        end
                    end else begin
                        if (bitcnt_q != FULL_BITS) begin
                            frame_err_q <= 1'b1;
                        end
                        bitcnt_q <= '0;
                        state_q  <= IDLE;
                    end
                end
                OVERRUN: begin
                    if (!DataMark) begin
                        frame_err_q <= 1'b1;
                        bitcnt_q    <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Reference register: LoadReg always wins so a same-cycle push does not
    // erase the freshly captured B; otherwise a push consumes the reference.
    always_ff @(posedge clk) begin
        if (clr) begin
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
        end else if (LoadReg) begin
            ref_q       <= B;
            ref_valid_q <= 1'b1;
        end else if (push) begin
            ref_valid_q <= 1'b0;
        end
    end

    // Receive FIFO: power-of-two depth lets the pointers wrap on overflow of
    // their own width. Storage is not reset; the outputs are gated by the
    // occupancy instead, so stale entries never show through.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            if (accept) begin
                mem_q[wr_ptr_q] <= entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + OCC_W'(1);
                2'b01:   count_q <= count_q - OCC_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign rx_valid    = (count_q != '0);
    assign rx_data     = rx_valid ? head[WIDTH-1:0] : '0;
    assign rx_mismatch = rx_valid & head[WIDTH];
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;
    assign count       = count_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_adc_serial_rx
//
// Directed bench for adc_serial_rx (WIDTH=8, FIFO_DEPTH=4). Inputs change
// 1 time unit after a rising edge, outputs are checked at the same point,
// so each check sees the state produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_adc_serial_rx;

    logic       clk;
    logic       clr;
    logic       DataMark;
    logic       SerialOutput;
    logic       LoadReg;
    logic [7:0] B;
    logic [7:0] rx_data;
    logic       rx_mismatch;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overflow;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;
    int feCount = 0;
    int ovCount = 0;
    int feBase;
    int ovBase;

    adc_serial_rx #(.WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .clr          (clr),
        .DataMark     (DataMark),
        .SerialOutput (SerialOutput),
        .LoadReg      (LoadReg),
        .B            (B),
        .rx_data      (rx_data),
        .rx_mismatch  (rx_mismatch),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .count        (count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters: every cycle frame_err or overflow is high is tallied,
    // so a pulse that is too long or appears twice shows up as a bad delta.
    always @(posedge clk) begin
        if (frame_err) feCount <= feCount + 1;
        if (overflow)  ovCount <= ovCount + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive len bits of word MSB-first with DataMark high, one per cycle.
    task automatic sendBits(input logic [15:0] word, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            DataMark     = 1'b1;
            SerialOutput = word[i];
            tick();
        end
        SerialOutput = 1'b0;
    endtask

    // Full frame plus the mandatory low cycle; returns in the cycle after E.
    task automatic applyStimulus(input logic [15:0] word, input int len);
        sendBits(word, len);
        DataMark = 1'b0;
        tick();
    endtask

    task automatic loadRef(input logic [7:0] value);
        B       = value;
        LoadReg = 1'b1;
        tick();
        LoadReg = 1'b0;
    endtask

    initial begin
        clr          = 1'b1;
        DataMark     = 1'b0;
        SerialOutput = 1'b0;
        LoadReg      = 1'b0;
        B            = 8'h00;
        rx_ready     = 1'b0;
        tick();
        tick();

        // Reset state
        checkOutput("reset_valid",    32'(rx_valid),    32'd0);
        checkOutput("reset_data",     32'(rx_data),     32'h00);
        checkOutput("reset_mismatch", 32'(rx_mismatch), 32'd0);
        checkOutput("reset_count",    32'(count),       32'd0);
        checkOutput("reset_frameerr", 32'(frame_err),   32'd0);
        checkOutput("reset_overflow", 32'(overflow),    32'd0);
        clr = 1'b0;
        tick();

        // Valid frame with a matching reference
        loadRef(8'hA5);
        rx_ready = 1'b1;
        applyStimulus(16'h00A5, 8);
        checkOutput("match_valid",    32'(rx_valid),    32'd1);
        checkOutput("match_data",     32'(rx_data),     32'hA5);
        checkOutput("match_mismatch", 32'(rx_mismatch), 32'd0);
        checkOutput("match_count",    32'(count),       32'd1);
        tick();
        checkOutput("match_count_pop", 32'(count),    32'd0);
        checkOutput("match_valid_pop", 32'(rx_valid), 32'd0);

        // Mismatch against a latched reference, then no reference at all
        loadRef(8'h3C);
        applyStimulus(16'h003D, 8);
        checkOutput("mis_data",     32'(rx_data),     32'h3D);
        checkOutput("mis_mismatch", 32'(rx_mismatch), 32'd1);
        tick();
        applyStimulus(16'h003D, 8);
        checkOutput("noref_data",     32'(rx_data),     32'h3D);
        checkOutput("noref_mismatch", 32'(rx_mismatch), 32'd0);
        tick();

        // Short frame (7 bits)
        feBase = feCount;
        applyStimulus(16'h007F, 7);
        checkOutput("short_frameerr", 32'(frame_err), 32'd1);
        checkOutput("short_count",    32'(count),     32'd0);
        checkOutput("short_valid",    32'(rx_valid),  32'd0);
        tick();
        checkOutput("short_frameerr_end", 32'(frame_err), 32'd0);
        checkOutput("short_pulses", 32'(feCount - feBase), 32'd1);

        // Long frame (9 bits)
        feBase = feCount;
        applyStimulus(16'h01AA, 9);
        checkOutput("long_frameerr", 32'(frame_err), 32'd1);
        checkOutput("long_count",    32'(count),     32'd0);
        checkOutput("long_valid",    32'(rx_valid),  32'd0);
        tick();
        checkOutput("long_frameerr_end", 32'(frame_err), 32'd0);
        checkOutput("long_pulses", 32'(feCount - feBase), 32'd1);

        // Fill the FIFO and overflow it with a fifth word
        rx_ready = 1'b0;
        ovBase   = ovCount;
        applyStimulus(16'h0001, 8);
        applyStimulus(16'h0002, 8);
        applyStimulus(16'h0003, 8);
        applyStimulus(16'h0004, 8);
        checkOutput("fill_count",    32'(count),    32'd4);
        checkOutput("fill_overflow", 32'(overflow), 32'd0);
        applyStimulus(16'h0005, 8);
        checkOutput("ovf_overflow", 32'(overflow), 32'd1);
        checkOutput("ovf_count",    32'(count),    32'd4);
        tick();
        checkOutput("ovf_overflow_end", 32'(overflow), 32'd0);
        checkOutput("ovf_pulses", 32'(ovCount - ovBase), 32'd1);
        rx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("ovf_pop%0d", i), 32'(rx_data), 32'(i));
            tick();
        end
        checkOutput("ovf_drained_valid", 32'(rx_valid), 32'd0);
        checkOutput("ovf_drained_count", 32'(count),    32'd0);

        // Simultaneous push and pop while full
        rx_ready = 1'b0;
        ovBase   = ovCount;
        applyStimulus(16'h0011, 8);
        applyStimulus(16'h0012, 8);
        applyStimulus(16'h0013, 8);
        applyStimulus(16'h0014, 8);
        checkOutput("pp_full_count", 32'(count), 32'd4);
        sendBits(16'h0015, 8);
        DataMark = 1'b0;
        rx_ready = 1'b1;
        tick();
        checkOutput("pp_count",    32'(count),    32'd4);
        checkOutput("pp_overflow", 32'(overflow), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            checkOutput($sformatf("pp_pop%0d", i), 32'(rx_data), 32'(8'h10 + i));
            tick();
        end
        checkOutput("pp_drained_valid", 32'(rx_valid), 32'd0);
        checkOutput("pp_no_overflow", 32'(ovCount - ovBase), 32'd0);

        // Reset in the middle of a frame with a word already queued
        rx_ready = 1'b0;
        applyStimulus(16'h0077, 8);
        checkOutput("rst_pre_count", 32'(count), 32'd1);
        feBase = feCount;
        sendBits(16'h000F, 4);
        clr      = 1'b1;
        DataMark = 1'b0;
        tick();
        checkOutput("rst_valid",    32'(rx_valid),  32'd0);
        checkOutput("rst_data",     32'(rx_data),   32'h00);
        checkOutput("rst_count",    32'(count),     32'd0);
        checkOutput("rst_frameerr", 32'(frame_err), 32'd0);
        checkOutput("rst_overflow", 32'(overflow),  32'd0);
        clr = 1'b0;
        tick();
        applyStimulus(16'h0081, 8);
        checkOutput("rst_rx_valid",    32'(rx_valid),    32'd1);
        checkOutput("rst_rx_data",     32'(rx_data),     32'h81);
        checkOutput("rst_rx_count",    32'(count),       32'd1);
        checkOutput("rst_rx_mismatch", 32'(rx_mismatch), 32'd0);
        rx_ready = 1'b1;
        tick();
        checkOutput("rst_rx_drained", 32'(count), 32'd0);
        checkOutput("rst_no_frameerr", 32'(feCount - feBase), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
